// File: rtl/cpu_pkg.sv
// cpu_pkg: shared micro-op codes, address map constants and state/region types
//   used by the store router and the load-side return mux.
package cpu_pkg;
    localparam logic [4:0]  UOP_LDR      = 5'd10;
    localparam logic [4:0]  UOP_STR      = 5'd11;
    localparam logic [31:0] DCACHE_WORDS = 32'd31;
    localparam logic [31:0] GPIO_ADDR    = 32'd31;
    typedef enum logic [1:0] {REGION_DCACHE, REGION_GPIO, REGION_UNMAPPED} region_e;
    typedef enum logic {ST_IDLE, ST_WRITE} store_state_e;
endpackage

// File: rtl/mem_addr_decode.sv
// mem_addr_decode: combinational address classifier shared by load and store paths.
//   addr   : 32-bit effective address (unsigned)
//   region : REGION_DCACHE for addr < DCACHE_WORDS, REGION_GPIO for addr == GPIO_ADDR,
//            REGION_UNMAPPED otherwise
module mem_addr_decode
    import cpu_pkg::region_e, cpu_pkg::REGION_DCACHE, cpu_pkg::REGION_GPIO, cpu_pkg::REGION_UNMAPPED;
#(
    parameter logic [31:0] DCACHE_WORDS = cpu_pkg::DCACHE_WORDS,
    parameter logic [31:0] GPIO_ADDR    = cpu_pkg::GPIO_ADDR
) (
    input  logic [31:0] addr,
    output region_e     region
);
    always_comb region = (addr < DCACHE_WORDS) ? REGION_DCACHE :
                         (addr == GPIO_ADDR)   ? REGION_GPIO   : REGION_UNMAPPED;
endmodule

// File: rtl/store_router.sv
// store_router: routes STR micro-ops to the D-cache (one-entry buffered write),
//   the GPIO output register, or drops and counts unmapped stores.
//   clk, reset_n        : clock, async active-low reset
//   valid/uop/addr/data : issuing micro-op from execute
//   stall               : holds the issuing stage while a D-cache write is pending
//   dcache_*            : D-cache write request, completes on an edge with dcache_ready
//   gpio_out            : GPIO output register
//   unmapped_count/flag : saturating count and sticky flag of unmapped stores
module store_router
    import cpu_pkg::region_e, cpu_pkg::REGION_DCACHE, cpu_pkg::REGION_GPIO, cpu_pkg::REGION_UNMAPPED,
           cpu_pkg::store_state_e, cpu_pkg::ST_IDLE, cpu_pkg::ST_WRITE, cpu_pkg::UOP_LDR, cpu_pkg::UOP_STR;
#(
    parameter logic [31:0] DCACHE_WORDS = cpu_pkg::DCACHE_WORDS,
    parameter logic [31:0] GPIO_ADDR    = cpu_pkg::GPIO_ADDR,
    parameter int          GPIO_WIDTH   = 8,
    parameter int          CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid,
    input  logic [4:0]            uop,
    input  logic [31:0]           addr,
    input  logic [31:0]           data,
    output logic                  stall,
    output logic                  dcache_we,
    output logic [4:0]            dcache_addr,
    output logic [31:0]           dcache_wdata,
    input  logic                  dcache_ready,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [CNT_WIDTH-1:0]  unmapped_count,
    output logic                  unmapped_flag
);
    store_state_e r_state, w_next;
    region_e      w_region;
    logic         w_mem_op, w_accept;

    mem_addr_decode #(.DCACHE_WORDS(DCACHE_WORDS), .GPIO_ADDR(GPIO_ADDR)) u_dec (
        .addr   (addr),
        .region (w_region)
    );

    // Loads also stall during WRITE so they can never bypass the pending store.
    assign w_mem_op = valid && (uop == UOP_LDR || uop == UOP_STR);
    assign w_accept = valid && uop == UOP_STR && !stall;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;

    always_comb
        w_next = (r_state == ST_IDLE) ? ((w_accept && w_region == REGION_DCACHE) ? ST_WRITE : ST_IDLE)
                                      : (dcache_ready ? ST_IDLE : ST_WRITE);

    always_comb begin
        stall     = r_state == ST_WRITE && w_mem_op;
        dcache_we = r_state == ST_WRITE;
    end

    // Accept is only possible in IDLE, so the write buffer is never overwritten mid-write.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            dcache_addr    <= '0;
            dcache_wdata   <= '0;
            gpio_out       <= '0;
            unmapped_count <= '0;
            unmapped_flag  <= 1'b0;
        end else if (w_accept) begin
            if (w_region == REGION_DCACHE) begin
                dcache_addr  <= addr[4:0];
                dcache_wdata <= data;
            end
            if (w_region == REGION_GPIO) gpio_out <= data[GPIO_WIDTH-1:0];
            if (w_region == REGION_UNMAPPED) begin
                unmapped_flag <= 1'b1;
                if (unmapped_count != '1) unmapped_count <= unmapped_count + 1'b1;
            end
        end
endmodule

// File: tb/tb_store_router.sv
// tb_store_router: table-driven directed checks of store_router plus hand-written
//   sequences for saturation and asynchronous reset during a write.
module tb_store_router;
    logic        clk = 1'b0, reset_n = 1'b0, valid = 1'b0, dcache_ready = 1'b1;
    logic [4:0]  uop = 5'd0;
    logic [31:0] addr = 32'd0, data = 32'd0;
    logic        stall, dcache_we, unmapped_flag;
    logic [4:0]  dcache_addr;
    logic [31:0] dcache_wdata;
    logic [7:0]  gpio_out, unmapped_count;
    int          errors = 0, checks = 0;

    store_router dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .uop(uop), .addr(addr), .data(data),
        .stall(stall), .dcache_we(dcache_we), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_ready(dcache_ready), .gpio_out(gpio_out), .unmapped_count(unmapped_count),
        .unmapped_flag(unmapped_flag)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] LDR = 5'd10, STR = 5'd11, ADD = 5'd1;

    typedef struct {
        logic        v;
        logic [4:0]  u;
        logic [31:0] a, d;
        logic        r, s, we;
        logic [4:0]  da;
        logic [31:0] dw;
        logic [7:0]  g, c;
        logic        f;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] u, input logic [31:0] a, input logic [31:0] d, input logic r);
        @(negedge clk);
        valid = v; uop = u; addr = a; data = d; dcache_ready = r;
        #2;
    endtask

    initial begin
        // Each row: inputs for this cycle, expected outputs observed before its rising edge.
        //              v  uop  addr          data          rdy stall we dadr  dwdata        gpio   cnt   flag
        tbl[0]  = '{1'b0, STR, 32'd7,        32'h0BADF00D, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        8'h00, 8'd0, 1'b0};
        tbl[1]  = '{1'b1, STR, 32'd5,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        8'h00, 8'd0, 1'b0};
        tbl[2]  = '{1'b0, STR, 32'd0,        32'h0,        1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 8'h00, 8'd0, 1'b0};
        tbl[3]  = '{1'b0, STR, 32'd0,        32'h0,        1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 8'h00, 8'd0, 1'b0};
        tbl[4]  = '{1'b1, STR, 32'd3,        32'h00000033, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 8'h00, 8'd0, 1'b0};
        tbl[5]  = '{1'b1, ADD, 32'd3,        32'h0,        1'b0, 1'b0, 1'b1, 5'd3, 32'h00000033, 8'h00, 8'd0, 1'b0};
        tbl[6]  = '{1'b1, LDR, 32'd3,        32'h0,        1'b0, 1'b1, 1'b1, 5'd3, 32'h00000033, 8'h00, 8'd0, 1'b0};
        tbl[7]  = '{1'b1, LDR, 32'd3,        32'h0,        1'b0, 1'b1, 1'b1, 5'd3, 32'h00000033, 8'h00, 8'd0, 1'b0};
        tbl[8]  = '{1'b1, LDR, 32'd3,        32'h0,        1'b1, 1'b1, 1'b1, 5'd3, 32'h00000033, 8'h00, 8'd0, 1'b0};
        tbl[9]  = '{1'b1, LDR, 32'd3,        32'h0,        1'b1, 1'b0, 1'b0, 5'd3, 32'h00000033, 8'h00, 8'd0, 1'b0};
        tbl[10] = '{1'b1, STR, 32'd31,       32'h12345678, 1'b1, 1'b0, 1'b0, 5'd3, 32'h00000033, 8'h00, 8'd0, 1'b0};
        tbl[11] = '{1'b0, STR, 32'd31,       32'h0,        1'b1, 1'b0, 1'b0, 5'd3, 32'h00000033, 8'h78, 8'd0, 1'b0};
        tbl[12] = '{1'b1, STR, 32'd32,       32'h000000AA, 1'b1, 1'b0, 1'b0, 5'd3, 32'h00000033, 8'h78, 8'd0, 1'b0};
        tbl[13] = '{1'b1, STR, 32'hFFFFFFFF, 32'h000000BB, 1'b1, 1'b0, 1'b0, 5'd3, 32'h00000033, 8'h78, 8'd1, 1'b1};
        tbl[14] = '{1'b1, STR, 32'd40,       32'h000000CC, 1'b1, 1'b0, 1'b0, 5'd3, 32'h00000033, 8'h78, 8'd2, 1'b1};
        tbl[15] = '{1'b0, STR, 32'd0,        32'h0,        1'b1, 1'b0, 1'b0, 5'd3, 32'h00000033, 8'h78, 8'd3, 1'b1};
        tbl[16] = '{1'b1, STR, 32'd0,        32'h00000011, 1'b1, 1'b0, 1'b0, 5'd3, 32'h00000033, 8'h78, 8'd3, 1'b1};
        tbl[17] = '{1'b1, STR, 32'd31,       32'h0000005A, 1'b1, 1'b1, 1'b1, 5'd0, 32'h00000011, 8'h78, 8'd3, 1'b1};
        tbl[18] = '{1'b1, STR, 32'd31,       32'h0000005A, 1'b1, 1'b0, 1'b0, 5'd0, 32'h00000011, 8'h78, 8'd3, 1'b1};
        tbl[19] = '{1'b0, STR, 32'd0,        32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 32'h00000011, 8'h5A, 8'd3, 1'b1};

        #3;
        chk("reset_we", 32'(dcache_we), 32'd0);
        chk("reset_gpio", 32'(gpio_out), 32'd0);
        chk("reset_cnt", 32'(unmapped_count), 32'd0);
        chk("reset_flag", 32'(unmapped_flag), 32'd0);
        chk("reset_addr", 32'(dcache_addr), 32'd0);
        chk("reset_wdata", dcache_wdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].u, tbl[i].a, tbl[i].d, tbl[i].r);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].s));
            chk($sformatf("v%0d_we", i), 32'(dcache_we), 32'(tbl[i].we));
            chk($sformatf("v%0d_daddr", i), 32'(dcache_addr), 32'(tbl[i].da));
            chk($sformatf("v%0d_wdata", i), dcache_wdata, tbl[i].dw);
            chk($sformatf("v%0d_gpio", i), 32'(gpio_out), 32'(tbl[i].g));
            chk($sformatf("v%0d_cnt", i), 32'(unmapped_count), 32'(tbl[i].c));
            chk($sformatf("v%0d_flag", i), 32'(unmapped_flag), 32'(tbl[i].f));
        end

        // 300 more unmapped stores: counter must saturate at 255, no writes, GPIO untouched.
        begin
            int we_seen = 0;
            for (int i = 0; i < 300; i++) begin
                drive(1'b1, STR, 32'd100 + 32'(i), 32'h000000EE, 1'b1);
                if (dcache_we || stall) we_seen++;
            end
            drive(1'b0, STR, 32'd0, 32'h0, 1'b1);
            chk("sat_cnt", 32'(unmapped_count), 32'd255);
            chk("sat_flag", 32'(unmapped_flag), 32'd1);
            chk("sat_no_we", 32'(we_seen), 32'd0);
            chk("sat_gpio", 32'(gpio_out), 32'h5A);
        end

        // Asynchronous reset in the middle of a D-cache write.
        drive(1'b1, STR, 32'd9, 32'hCAFEF00D, 1'b0);
        drive(1'b1, LDR, 32'd9, 32'h0, 1'b0);
        chk("rst_pre_we", 32'(dcache_we), 32'd1);
        chk("rst_pre_stall", 32'(stall), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_we", 32'(dcache_we), 32'd0);
        chk("rst_async_stall", 32'(stall), 32'd0);
        chk("rst_async_gpio", 32'(gpio_out), 32'd0);
        chk("rst_async_cnt", 32'(unmapped_count), 32'd0);
        chk("rst_async_flag", 32'(unmapped_flag), 32'd0);
        chk("rst_async_wdata", dcache_wdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, LDR, 32'd9, 32'h0, 1'b1);
        chk("rst_rel_we", 32'(dcache_we), 32'd0);
        chk("rst_rel_stall", 32'(stall), 32'd0);
        drive(1'b0, STR, 32'd0, 32'h0, 1'b1);
        chk("rst_rel_we2", 32'(dcache_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
